credit_arbiter: RTL

Five-port (N, E, W, S, L) output-port arbiter for the router, using credit-based flow control toward the downstream input buffer instead of an RTS/DCTS handshake. It grants one requesting input per cycle and drives the crossbar select for its output port. It tracks free downstream buffer slots with a credit counter. A grant is held for as long as the owning input keeps requesting (wormhole packet lock), then rotates round-robin.

---
 rtl/credit_arbiter_if.sv | 28 ++
 rtl/credit_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/credit_arbiter_if.sv
// Output-port bundle for credit_arbiter: input requests, grants, crossbar select and credit flow control.
// The arbiter is bound through the slave modport. The requester/bench side uses the master modport.
interface credit_arbiter_if #(
  parameter int CREDIT_MAX = 4
);
  localparam int CNT_W = $clog2(CREDIT_MAX + 1);

  logic             Req_N, Req_E, Req_W, Req_S, Req_L;
  logic             credit_in;
  logic             Grant_N, Grant_E, Grant_W, Grant_S, Grant_L;
  logic [4:0]       Xbar_sel;
  logic             valid_out;
  logic [CNT_W-1:0] credit_cnt;
  logic             credit_err;
  logic [5:0]       dbg_state;

  modport master (
    output Req_N, Req_E, Req_W, Req_S, Req_L, credit_in,
    input  Grant_N, Grant_E, Grant_W, Grant_S, Grant_L,
    input  Xbar_sel, valid_out, credit_cnt, credit_err, dbg_state
  );

  modport slave (
    input  Req_N, Req_E, Req_W, Req_S, Req_L, credit_in,
    output Grant_N, Grant_E, Grant_W, Grant_S, Grant_L,
    output Xbar_sel, valid_out, credit_cnt, credit_err, dbg_state
  );
endinterface

// File: rtl/credit_arbiter.sv
// Five-input round-robin output-port arbiter with a wormhole packet lock and downstream credit counting.
// Handshake: Grant_X means one flit from input X crosses this cycle, and it consumes one downstream credit.
module credit_arbiter #(
  parameter int CREDIT_MAX = 4
) (
  input logic             clk,
  input logic             rst,
  credit_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(CREDIT_MAX + 1);

  typedef enum logic [5:0] {
    ST_IDLE = 6'b000001,
    ST_L    = 6'b000010,
    ST_N    = 6'b000100,
    ST_E    = 6'b001000,
    ST_W    = 6'b010000,
    ST_S    = 6'b100000
  } state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [4:0]       w_req, w_sel, w_grant;
  logic [2:0]       w_cur, w_idx;
  logic             w_found, w_valid;

  // Bit order N,E,W,S,L is both the Xbar_sel encoding and the round-robin order.
  assign w_req = {bus.Req_L, bus.Req_S, bus.Req_W, bus.Req_E, bus.Req_N};

  function automatic state_t idx_to_state(input logic [2:0] idx);
    case (idx)
      3'd0:    return ST_N;
      3'd1:    return ST_E;
      3'd2:    return ST_W;
      3'd3:    return ST_S;
      default: return ST_L;
    endcase
  endfunction

  // IDLE searches as if it had just served S, which yields priority L,N,E,W,S.
  always_comb begin
    w_sel = 5'b00000;
    w_cur = 3'd3;
    case (r_state)
      ST_N:    begin w_sel = 5'b00001; w_cur = 3'd0; end
      ST_E:    begin w_sel = 5'b00010; w_cur = 3'd1; end
      ST_W:    begin w_sel = 5'b00100; w_cur = 3'd2; end
      ST_S:    begin w_sel = 5'b01000; w_cur = 3'd3; end
      ST_L:    begin w_sel = 5'b10000; w_cur = 3'd4; end
      default: begin w_sel = 5'b00000; w_cur = 3'd3; end
    endcase
  end

  always_comb begin
    w_next  = ST_IDLE;
    w_found = 1'b0;
    w_idx   = 3'd0;
    if ((w_sel & w_req) != 5'b00000) begin
      // The lock holds while the owner keeps requesting, even if stalled on credits.
      w_next = r_state;
    end else begin
      for (int k = 0; k < 5; k++) begin
        w_idx = 3'((32'(w_cur) + 32'd1 + 32'(k)) % 32'd5);
        if (!w_found && w_req[w_idx]) begin
          w_found = 1'b1;
          w_next  = idx_to_state(w_idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  assign w_grant = (rst || r_cnt == '0) ? 5'b00000 : (w_sel & w_req);
  assign w_valid = |w_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= CNT_W'(CREDIT_MAX);
      r_err <= 1'b0;
    end else begin
      case ({w_valid, bus.credit_in})
        2'b10: r_cnt <= r_cnt - 1'b1;
        2'b01: begin
          if (r_cnt == CNT_W'(CREDIT_MAX)) r_err <= 1'b1;
          else                             r_cnt <= r_cnt + 1'b1;
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.Grant_N    = w_grant[0];
  assign bus.Grant_E    = w_grant[1];
  assign bus.Grant_W    = w_grant[2];
  assign bus.Grant_S    = w_grant[3];
  assign bus.Grant_L    = w_grant[4];
  assign bus.valid_out  = w_valid;
  assign bus.Xbar_sel   = rst ? 5'b00000 : w_sel;
  assign bus.credit_cnt = r_cnt;
  assign bus.credit_err = r_err;
  assign bus.dbg_state  = r_state;
endmodule
